// File: rtl/gpio_seq_ctrl.sv
// Wishbone control/status front end for the GPIO sequencer: run FSM,
// sticky maskable done interrupt, shadowed prescaler and a completed-run counter.
module gpio_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [13:0] PRESCALER_RESET = 14'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        done,
  output logic        enable,
  output logic        stop,
  output logic [13:0] prescaler,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_COMPLETE,
    S_ABORTING
  } state_e;

  state_e      state_q, state_d;
  logic        ack_q;
  logic [31:0] dat_q, dat_d;
  logic [13:0] shadow_q, shadow_d;
  logic [13:0] presc_q, presc_d;
  logic        auto_q, auto_d;
  logic        irq_en_q, irq_en_d;
  logic        sdone_q, sdone_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q;

  logic        req, wr_req, rd_req;
  logic [3:0]  off;
  logic        wr_presc, ctrl_b0, wr_w1c;
  logic        start_wr, abort_wr, done_pulse;
  logic        done_set, cnt_inc, reload;
  logic [13:0] shadow_merge;
  logic        unused_bits;

  assign off      = wbs_adr_i[3:0];
  // Holding off while ack is high forces a one-cycle gap between back-to-back requests.
  assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_req   = req & wbs_we_i;
  assign rd_req   = req & ~wbs_we_i;
  assign wr_presc = wr_req & (off == 4'h0);
  assign ctrl_b0  = wr_req & (off == 4'h4) & wbs_sel_i[0];
  assign wr_w1c   = wr_req & (off == 4'h8) & wbs_sel_i[0] & wbs_dat_i[0];
  assign start_wr = ctrl_b0 & wbs_dat_i[0];
  assign abort_wr = ctrl_b0 & wbs_dat_i[1];
  assign done_pulse = done & ~done_q;

  assign unused_bits = ^{wbs_dat_i[31:14], wbs_sel_i[3:2]};

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    cnt_inc  = 1'b0;
    reload   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        reload = 1'b1;
        if (start_wr && !abort_wr) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort_wr)        state_d = S_ABORTING;
        else if (done_pulse) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        done_set = 1'b1;
        cnt_inc  = 1'b1;
        state_d  = auto_q ? S_RUN : S_IDLE;
      end
      S_ABORTING: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_merge = {wbs_sel_i[1] ? wbs_dat_i[13:8] : shadow_q[13:8],
                    wbs_sel_i[0] ? wbs_dat_i[7:0]  : shadow_q[7:0]};
    shadow_d = shadow_q;
    if (wr_presc) shadow_d = (shadow_merge == 14'd0) ? 14'd1 : shadow_merge;

    auto_d   = ctrl_b0 ? wbs_dat_i[2] : auto_q;
    irq_en_d = ctrl_b0 ? wbs_dat_i[3] : irq_en_q;
    presc_d  = reload ? shadow_q : presc_q;
    // Set wins over a same-cycle write-1-to-clear.
    sdone_d  = done_set ? 1'b1 : (wr_w1c ? 1'b0 : sdone_q);
    cnt_d    = (cnt_inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    dat_d = 32'd0;
    if (rd_req) begin
      unique case (off)
        4'h0:    dat_d = {18'd0, shadow_q};
        4'h4:    dat_d = {28'd0, irq_en_q, auto_q, 2'b00};
        4'h8:    dat_d = {30'd0, state_q == S_RUN, sdone_q};
        4'hC:    dat_d = {16'd0, cnt_q};
        default: dat_d = 32'd0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      shadow_q <= PRESCALER_RESET;
      presc_q  <= PRESCALER_RESET;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      sdone_q  <= 1'b0;
      cnt_q    <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= req;
      dat_q    <= dat_d;
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      sdone_q  <= sdone_d;
      cnt_q    <= cnt_d;
      done_q   <= done;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign enable    = (state_q == S_RUN);
  assign stop      = (state_q == S_COMPLETE) || (state_q == S_ABORTING);
  assign prescaler = presc_q;
  assign irq       = sdone_q & irq_en_q;

endmodule

// File: doc/gpio_seq_ctrl.md
Name: gpio_seq_ctrl

Overview:
- Wishbone-slave control and status front end that sits directly upstream of the GPIO sequencer.
- Drives the sequencer's enable, stop and 14-bit prescaler inputs, and consumes its done output.
- Converts firmware register writes into a run state machine and turns done into a sticky, maskable interrupt.
- Counts completed sequences.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 16-byte register window; only adr[31:4] is compared.
- PRESCALER_RESET, 14'd1, reset value of the shadow and active prescaler.

Ports:
- clk  input  1  system clock, 10 MHz.
- rst  input  1  asynchronous reset, active-high.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  1 = write.
- wbs_sel_i  input  4  byte enables.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- done  input  1  sequence-complete flag from the sequencer.
- enable  output  1  run enable to the sequencer.
- stop  output  1  synchronous clear to the sequencer.
- prescaler  output  14  active prescaler to the sequencer.
- irq  output  1  interrupt to the management core.

Behaviour:
- Reset: rst asynchronous, active-high. While asserted, all flops clear; state=IDLE.
  - enable, stop, irq, wbs_ack_o = 0; wbs_dat_o = 0.
  - prescaler and shadow = PRESCALER_RESET.
  - CTRL = 0, STATUS = 0, RUN_COUNT = 0, done_q = 0.
- Register map (offset from BASE_ADDR):
  - 0x00 PRESCALER: RW shadow[13:0]; upper bits read 0. A written value of 0 is stored as 1.
  - 0x04 CTRL:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 ABORT: write-1 pulse, reads 0.
    - bit2 AUTO_RESTART: RW.
    - bit3 IRQ_EN: RW.
  - 0x08 STATUS: bit0 DONE (sticky, write-1-to-clear), bit1 RUNNING (RO, =1 in RUN).
  - 0x0C RUN_COUNT: RO [15:0], saturates at 16'hFFFF.
- Bus handshake:
  - A request is cyc & stb & ~wbs_ack_o & address in window.
  - wbs_ack_o rises the cycle after the request for exactly one cycle, so latency is 1 and back-to-back requests are acked on alternate cycles.
  - Read data is valid with ack.
  - Out-of-window addresses are never acked.
  - In-window unmapped offsets: writes are ignored, reads return 0.
  - Write effects commit on the request cycle.
  - Byte enables apply per byte; START, ABORT, AUTO_RESTART and IRQ_EN require sel[0].
- Done detection: done_q registers done; done_pulse = done & ~done_q (rising edge only).
- FSM, states IDLE / RUN / COMPLETE / ABORTING:
  - IDLE: enable=0, stop=0; prescaler <= shadow every cycle. START -> RUN. If START and ABORT arrive in the same write, stay IDLE.
  - RUN: enable=1; prescaler is frozen.
    - ABORT -> ABORTING; ABORT has priority over done_pulse in the same cycle.
    - done_pulse -> COMPLETE.
    - START is ignored.
  - COMPLETE (1 cycle): enable=0, stop=1; DONE set; RUN_COUNT increments. Next state is RUN if AUTO_RESTART=1, else IDLE.
    - With auto-restart, prescaler is not reloaded from shadow.
  - ABORTING (1 cycle): enable=0, stop=1; DONE unchanged -> IDLE.
- DONE write-1-to-clear in the same cycle DONE is set: set wins.
- irq = DONE & IRQ_EN, driven from flops with no combinational path from bus inputs. Clearing IRQ_EN masks irq without clearing DONE.
- Writes to shadow during RUN are readable immediately and take effect only after the FSM returns to IDLE.
- rst mid-run returns all state to reset values; the sequencer sees enable=0 immediately.

Test Plan:
1. Reset, then read 0x00/0x04/0x08/0x0C -> 0x1, 0x0, 0x0, 0x0. Each ack arrives exactly 1 cycle after stb and lasts 1 cycle.
2. Write PRESCALER=5 then CTRL=0x9 (START, IRQ_EN) -> next cycle enable=1, prescaler=5.
   - Pulse done high for 3 cycles -> one COMPLETE cycle with stop=1, enable=0.
   - STATUS=0x1, irq=1, RUN_COUNT=1.
   - Write STATUS=0x1 -> irq=0.
3. During RUN write PRESCALER=0 -> readback 1, prescaler output stays 5.
   - ABORT -> one stop cycle, DONE=0, RUN_COUNT unchanged.
   - Output becomes 1 in IDLE.
4. AUTO_RESTART=1 with START; two done rising edges -> enable low for exactly 1 cycle each time, RUN_COUNT=2, FSM back in RUN.
5. ABORT write on the same cycle as a done rising edge -> ABORTING taken, DONE=0. Separately, W1C of DONE on the same cycle as COMPLETE -> DONE=1.
6. Access BASE_ADDR+0x20 -> no ack within 5 cycles. Read BASE_ADDR+0x10-aligned unmapped offset -> ack with data 0. Assert rst mid-RUN -> enable, stop, irq = 0 asynchronously.
